i2s_tx: RTL and testbench

//  I2S transmitter for the audio path. Serialises stereo sample pairs from a valid/ready stream onto sda,
//  and generates the matching lrclk. Frame: 34 bclk per frame, 17 slots per channel.

---
 rtl/i2s_tx_pkg.sv | 10 +
 rtl/i2s_tx_hold.sv | 33 +++
 rtl/i2s_tx.sv | 80 ++++++++
 tb/tb_i2s_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tx_pkg.sv
// i2s_tx_pkg: frame geometry shared by the I2S transmit and receive blocks
package i2s_tx_pkg;
  localparam int I2S_SAMPLE_W = 16;
  function automatic int frame_bits(input int sw);
    return 2 * sw + 2;
  endfunction
  function automatic int right_slot(input int sw);
    return sw + 1;
  endfunction
endpackage

// File: rtl/i2s_tx_hold.sv
// i2s_tx_hold: one-entry valid/ready holding register; take and refill may share an edge
module i2s_tx_hold #(
  parameter int W = 32
) (
  input  logic         bclk,
  input  logic         rstn,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         take_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);
  logic         full_q, full_d, acc;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    ready_o = !full_q | take_i;
    acc     = valid_i & ready_o;
    full_d  = acc | (full_q & !take_i);
    data_d  = acc ? data_i : data_q;
  end
  always_ff @(posedge bclk) begin
    if (!rstn) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
  assign data_o = data_q;
  assign full_o = full_q;
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter, stereo pairs serialised MSB-first with one delay bit per channel
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int SAMPLE_W   = I2S_SAMPLE_W,
  parameter bit UNDERRUN_Z = 1'b1
) (
  input  logic                  bclk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [2*SAMPLE_W-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic                  lrclk,
  output logic                  sda,
  output logic                  frame_start,
  output logic                  underrun
);
  localparam int FB = frame_bits(SAMPLE_W);
  localparam int CW = $clog2(FB);
  localparam logic [CW-1:0] LAST_SLOT = CW'(FB - 1);
  localparam logic [CW-1:0] R_SLOT = CW'(right_slot(SAMPLE_W));
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FB-1:0]         shift_q, shift_d;
  logic [2*SAMPLE_W-1:0] last_q, last_d, hold_data, src;
  logic                  run_q, run_d, fs_q, ur_q, sda_q, lrclk_q;
  logic                  hold_full, at_end, load;
  i2s_tx_hold #(.W(2*SAMPLE_W)) u_hold (
    .bclk   (bclk),
    .rstn   (rstn),
    .data_i (s_tdata),
    .valid_i(s_tvalid),
    .ready_o(s_tready),
    .take_i (load),
    .data_o (hold_data),
    .full_o (hold_full)
  );
  // run_q marks a frame on the wire; it gates outputs low while parked at the last slot
  always_comb begin
    at_end  = cnt_q == LAST_SLOT;
    load    = at_end & en;
    src     = hold_full ? hold_data : (UNDERRUN_Z ? '0 : last_q);
    last_d  = (load & hold_full) ? hold_data : last_q;
    cnt_d   = load ? '0 : at_end ? cnt_q : cnt_q + 1'b1;
    shift_d = load ? {1'b0, src[2*SAMPLE_W-1 -: SAMPLE_W], 1'b0, src[SAMPLE_W-1:0]}
                   : at_end ? shift_q : shift_q << 1;
    run_d   = load | (run_q & !at_end);
  end
  always_ff @(posedge bclk) begin
    if (!rstn) begin
      cnt_q   <= LAST_SLOT;
      shift_q <= '0;
      last_q  <= '0;
      run_q   <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      run_q   <= run_d;
      fs_q    <= load;
      ur_q    <= load & !hold_full;
    end
  end
  // launch on the falling edge so the far end samples mid-bit on its rising edge
  always_ff @(negedge bclk) begin
    if (!rstn) begin
      sda_q   <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      sda_q   <= shift_q[FB-1] & run_q;
      lrclk_q <= (cnt_q >= R_SLOT) & run_q;
    end
  end
  assign sda         = sda_q;
  assign lrclk       = lrclk_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed + random checks of i2s_tx against a frame-level scoreboard
module tb_i2s_tx;
  typedef struct packed {
    logic [33:0] d;
    logic [33:0] lr;
    logic        u;
  } frame_t;
  logic        bclk = 1'b0, rstn = 1'b0, en = 1'b0, s_tvalid = 1'b0;
  logic [31:0] s_tdata = '0;
  wire  [1:0]  rdy, lrc, sd, fs, ur;
  frame_t      mon0[$], mon1[$];
  logic [31:0] exp0[$], exp1[$];
  logic [31:0] last1 = '0;
  int vectors = 0, errors = 0, cyc = 0, ur_cnt = 0, fs_cnt = 0, acc_cyc = 0;
  always #5 bclk = ~bclk;
  i2s_tx #(.SAMPLE_W(16), .UNDERRUN_Z(1'b1)) dut_z (
    .bclk(bclk), .rstn(rstn), .en(en), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(rdy[0]), .lrclk(lrc[0]), .sda(sd[0]), .frame_start(fs[0]), .underrun(ur[0]));
  i2s_tx #(.SAMPLE_W(16), .UNDERRUN_Z(1'b0)) dut_r (
    .bclk(bclk), .rstn(rstn), .en(en), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(rdy[1]), .lrclk(lrc[1]), .sda(sd[1]), .frame_start(fs[1]), .underrun(ur[1]));

  // receiver: frame_start/underrun latched mid-cycle, line sampled on rising bclk
  initial begin
    frame_t cur[2];
    int     k[2];
    bit     cap[2];
    logic [1:0] fsl, url;
    cap[0] = 0; cap[1] = 0; k[0] = 0; k[1] = 0;
    cur[0] = '0; cur[1] = '0;
    forever begin
      @(negedge bclk);
      fsl = fs; url = ur;
      @(posedge bclk);
      cyc++;
      if (url[0]) ur_cnt++;
      if (fsl[0]) fs_cnt++;
      for (int j = 0; j < 2; j++) begin
        if (!rstn) cap[j] = 0;
        else begin
          if (fsl[j]) begin cap[j] = 1; k[j] = 0; cur[j].u = url[j]; end
          if (cap[j]) begin
            cur[j].d[33-k[j]]  = sd[j];
            cur[j].lr[33-k[j]] = lrc[j];
            if (k[j] == 33) begin
              cap[j] = 0;
              if (j == 0) mon0.push_back(cur[j]); else mon1.push_back(cur[j]);
            end else k[j]++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic push(input logic [31:0] w);
    bit ok = 0;
    s_tdata = w; s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      ok = rdy[0];
      tick();
    end
    chk("push_accept", 32'(ok), 32'd1);
    if (ok) begin exp0.push_back(w); exp1.push_back(w); end
    acc_cyc = cyc;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_fs(input string tag);
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = fs[0];
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  // every captured frame is {0,L,0,R} of the next sent word, or the underrun fill
  task automatic check_frames();
    frame_t      f;
    logic [31:0] w;
    int          n;
    for (int j = 0; j < 2; j++) begin
      n = (j == 0) ? mon0.size() : mon1.size();
      for (int i = 0; i < n; i++) begin
        if (j == 0) f = mon0.pop_front(); else f = mon1.pop_front();
        if (f.u) w = (j == 0) ? 32'h0 : last1;
        else begin
          chk($sformatf("frame_has_data%0d", j), 32'((j == 0) ? exp0.size() : exp1.size()) > 0 ? 32'd1 : 32'd0, 32'd1);
          w = 32'h0;
          if (j == 0 && exp0.size() > 0) w = exp0.pop_front();
          if (j == 1 && exp1.size() > 0) w = exp1.pop_front();
        end
        if (j == 1) last1 = w;
        vectors++;
        assert (f.d === {1'b0, w[31:16], 1'b0, w[15:0]}) else begin
          errors++;
          $error("FAIL sda_frame%0d: got %h want %h", j, f.d, {1'b0, w[31:16], 1'b0, w[15:0]});
        end
        vectors++;
        assert (f.lr === {17'h0, 17'h1ffff}) else begin
          errors++;
          $error("FAIL lrclk_frame%0d: got %h want %h", j, f.lr, {17'h0, 17'h1ffff});
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8000; i++) begin
      tick();
      check_frames();
      if (exp0.size() == 0 && exp1.size() == 0) break;
    end
    chk("drain", 32'(exp0.size() + exp1.size()), 32'd0);
  endtask

  initial begin
    int t1, ura, fsa;
    repeat (3) tick();
    chk("rst_fs", 32'(fs), 32'd0);
    chk("rst_ur", 32'(ur), 32'd0);
    chk("rst_ready", 32'(rdy), 32'h3);
    @(negedge bclk); #1;
    chk("rst_lrclk", 32'(lrc), 32'd0);
    chk("rst_sda", 32'(sd), 32'd0);
    tick();
    rstn = 1'b1;
    // first frame: word parked in hold while disabled, then enable
    push(32'hA5C3_0F0F);
    chk("hold_full_ready", 32'(rdy[0]), 32'd0);
    en = 1'b1;
    wait_fs("first_load");
    chk("first_latency", 32'(cyc - acc_cyc), 32'd1);
    chk("first_ur", 32'(ur[0]), 32'd0);
    @(negedge bclk); #1;
    chk("delay_bit", 32'(sd[0]), 32'd0);
    tick();
    @(negedge bclk); #1;
    chk("l15_bit", 32'(sd[0]), 32'd1);
    // back-to-back stream of 8 pairs
    push($urandom);
    push($urandom);
    t1 = acc_cyc; ura = ur_cnt; fsa = fs_cnt;
    chk("b2b_ready_low", 32'(rdy[0]), 32'd0);
    for (int i = 2; i < 8; i++) push($urandom);
    wait_fs("b2b_last_load");
    chk("b2b_period", 32'(cyc - t1), 32'd238);
    tick();
    chk("b2b_no_underrun", 32'(ur_cnt - ura), 32'd0);
    chk("b2b_frames", 32'(fs_cnt - fsa), 32'd8);
    // hold now empty: next load underruns exactly once
    wait_fs("ur_load");
    chk("ur_pulse", 32'(ur), 32'h3);
    tick();
    chk("ur_once", 32'(ur), 32'd0);
    // en dropped mid-frame with a word waiting
    push($urandom);
    push($urandom);
    repeat (10) tick();
    en = 1'b0;
    repeat (40) tick();
    for (int i = 0; i < 3; i++) begin
      chk("idle_lrclk", 32'(lrc), 32'd0);
      chk("idle_sda", 32'(sd), 32'd0);
      chk("idle_fs", 32'(fs), 32'd0);
      chk("idle_ready", 32'(rdy[0]), 32'd0);
      tick();
    end
    en = 1'b1;
    tick();
    chk("resume_fs", 32'(fs[0]), 32'd1);
    chk("resume_ur", 32'(ur[0]), 32'd0);
    // reset mid-frame with hold full
    push($urandom);
    repeat (19) tick();
    check_frames();
    rstn = 1'b0;
    tick();
    @(negedge bclk); #1;
    chk("midrst_lrclk", 32'(lrc), 32'd0);
    chk("midrst_sda", 32'(sd), 32'd0);
    chk("midrst_ready", 32'(rdy), 32'h3);
    exp0.delete(); exp1.delete(); last1 = '0;
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_fs", 32'(fs[0]), 32'd1);
    chk("post_rst_ur", 32'(ur[0]), 32'd1);
    // random loopback
    for (int i = 0; i < 100; i++) push($urandom);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
